// File: rtl/eth_rx_frame_dispatcher.sv
// Per-frame header filter/classifier feeding a first-word-fall-through descriptor FIFO.
// A capture stage, then an evaluate stage that either pushes a descriptor or counts the drop reason.
module eth_rx_frame_dispatcher #(
    parameter int DESC_DEPTH = 4,
    parameter int LEN_W      = 11,
    parameter int CNT_W      = 16
) (
    input  logic             rx_clk,
    input  logic             reset,
    input  logic [47:0]      cfg_mac,
    input  logic             cfg_promisc,
    input  logic             cfg_accept_mcast,
    input  logic             cfg_accept_other,
    input  logic             hdr_valid,
    input  logic [47:0]      hdr_dst_mac,
    input  logic [47:0]      hdr_src_mac,
    input  logic [15:0]      hdr_ethertype,
    input  logic [LEN_W-1:0] hdr_len,
    input  logic             hdr_err,
    output logic             desc_valid,
    input  logic             desc_ready,
    output logic [1:0]       desc_class,
    output logic [47:0]      desc_src_mac,
    output logic [LEN_W-1:0] desc_len,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] drop_err_cnt,
    output logic [CNT_W-1:0] drop_filter_cnt,
    output logic [CNT_W-1:0] drop_full_cnt
);
    localparam int PW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [1:0]       cls;
        logic [47:0]      src;
        logic [LEN_W-1:0] len;
    } desc_t;

    // Capture stage: header plus a cfg snapshot so mid-flight cfg changes don't affect this frame
    logic             eval_pending;
    logic [47:0]      cap_dst, cap_src, cap_mac;
    logic [15:0]      cap_type;
    logic [LEN_W-1:0] cap_len;
    logic             cap_err, cap_promisc, cap_mcast, cap_other;

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            eval_pending <= 1'b0;
        end else begin
            eval_pending <= hdr_valid;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (hdr_valid) begin
            cap_dst     <= hdr_dst_mac;
            cap_src     <= hdr_src_mac;
            cap_type    <= hdr_ethertype;
            cap_len     <= hdr_len;
            cap_err     <= hdr_err;
            cap_mac     <= cfg_mac;
            cap_promisc <= cfg_promisc;
            cap_mcast   <= cfg_accept_mcast;
            cap_other   <= cfg_accept_other;
        end
    end

    logic [1:0]    cls;
    logic          mac_ok, type_ok, full, pop;
    logic          ev_err, ev_filt, ev_full, push;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    desc_t         mem [DESC_DEPTH];

    always_comb begin
        case (cap_type)
            16'h0806: cls = 2'd0;
            16'h0800: cls = 2'd1;
            16'h86DD: cls = 2'd2;
            default:  cls = 2'd3;
        endcase
        mac_ok  = cap_promisc || (cap_dst == cap_mac) || (&cap_dst) ||
                  (cap_mcast && cap_dst[40]);
        type_ok = (cls != 2'd3) || cap_other;
        // Full uses the registered count, so a same-cycle pop never makes room
        full    = (count == CW'(DESC_DEPTH));
        ev_err  = eval_pending && cap_err;
        ev_filt = eval_pending && !cap_err && !(mac_ok && type_ok);
        ev_full = eval_pending && !cap_err && mac_ok && type_ok && full;
        push    = eval_pending && !cap_err && mac_ok && type_ok && !full;
        pop     = desc_valid && desc_ready;
    end

    always_ff @(posedge rx_clk) begin
        if (push) mem[wr_ptr] <= '{cls: cls, src: cap_src, len: cap_len};
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            accept_cnt      <= '0;
            drop_err_cnt    <= '0;
            drop_filter_cnt <= '0;
            drop_full_cnt   <= '0;
        end else begin
            if (push    && !(&accept_cnt))      accept_cnt      <= accept_cnt + CNT_W'(1);
            if (ev_err  && !(&drop_err_cnt))    drop_err_cnt    <= drop_err_cnt + CNT_W'(1);
            if (ev_filt && !(&drop_filter_cnt)) drop_filter_cnt <= drop_filter_cnt + CNT_W'(1);
            if (ev_full && !(&drop_full_cnt))   drop_full_cnt   <= drop_full_cnt + CNT_W'(1);
        end
    end

    // Head entry is masked to zero when empty so stale contents never leak out
    desc_t head;
    assign desc_valid   = (count != '0);
    assign head         = desc_valid ? mem[rd_ptr] : '0;
    assign desc_class   = head.cls;
    assign desc_src_mac = head.src;
    assign desc_len     = head.len;
endmodule

// File: tb/tb_eth_rx_frame_dispatcher.sv
// Directed bench for eth_rx_frame_dispatcher: filtering, classes, full FIFO, back-to-back, saturation, reset.
module tb_eth_rx_frame_dispatcher;
    localparam int LEN_W = 11;
    localparam int CNT_W = 16;
    localparam logic [47:0] STA   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] SRC   = 48'h0A_0B_0C_0D_0E_0F;

    logic             rx_clk = 1'b0;
    logic             reset;
    logic [47:0]      cfg_mac;
    logic             cfg_promisc, cfg_accept_mcast, cfg_accept_other;
    logic             hdr_valid;
    logic [47:0]      hdr_dst_mac, hdr_src_mac;
    logic [15:0]      hdr_ethertype;
    logic [LEN_W-1:0] hdr_len;
    logic             hdr_err;
    logic             desc_valid, desc_ready;
    logic [1:0]       desc_class;
    logic [47:0]      desc_src_mac;
    logic [LEN_W-1:0] desc_len;
    logic [CNT_W-1:0] accept_cnt, drop_err_cnt, drop_filter_cnt, drop_full_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    eth_rx_frame_dispatcher #(.DESC_DEPTH(4), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .rx_clk(rx_clk), .reset(reset), .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc),
        .cfg_accept_mcast(cfg_accept_mcast), .cfg_accept_other(cfg_accept_other),
        .hdr_valid(hdr_valid), .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
        .hdr_ethertype(hdr_ethertype), .hdr_len(hdr_len), .hdr_err(hdr_err),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_class(desc_class),
        .desc_src_mac(desc_src_mac), .desc_len(desc_len), .accept_cnt(accept_cnt),
        .drop_err_cnt(drop_err_cnt), .drop_filter_cnt(drop_filter_cnt),
        .drop_full_cnt(drop_full_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge rx_clk);
        #1;
    endtask

    // Drive one header pulse; returns just after the capture edge
    task automatic send(input logic [47:0] dst, input logic [15:0] et,
                        input logic [LEN_W-1:0] len, input logic err);
        hdr_dst_mac   = dst;
        hdr_src_mac   = SRC;
        hdr_ethertype = et;
        hdr_len       = len;
        hdr_err       = err;
        hdr_valid     = 1'b1;
        step();
        hdr_valid     = 1'b0;
    endtask

    task automatic pop1();
        desc_ready = 1'b1;
        step();
        desc_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", desc_valid); end
        n_cmp++; if (desc_class !== 2'd0) begin n_bad++; $display("FAIL rst_class: got %0h want 0", desc_class); end
        n_cmp++; if (desc_src_mac !== 48'd0) begin n_bad++; $display("FAIL rst_src: got %0h want 0", desc_src_mac); end
        n_cmp++; if (desc_len !== '0) begin n_bad++; $display("FAIL rst_len: got %0h want 0", desc_len); end
        n_cmp++; if ({accept_cnt, drop_err_cnt, drop_filter_cnt, drop_full_cnt} !== '0) begin
            n_bad++; $display("FAIL rst_cnts: got %0h %0h %0h %0h want all 0",
                              accept_cnt, drop_err_cnt, drop_filter_cnt, drop_full_cnt); end
    endtask

    task automatic test_unicast();
        send(STA, 16'h0800, 11'd60, 1'b0);
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL uc_early_valid: got %0h want 0", desc_valid); end
        step();
        n_cmp++; if (desc_valid !== 1'b1) begin n_bad++; $display("FAIL uc_valid: got %0h want 1", desc_valid); end
        n_cmp++; if (desc_class !== 2'd1) begin n_bad++; $display("FAIL uc_class: got %0d want 1", desc_class); end
        n_cmp++; if (desc_len !== 11'd60) begin n_bad++; $display("FAIL uc_len: got %0d want 60", desc_len); end
        n_cmp++; if (desc_src_mac !== SRC) begin n_bad++; $display("FAIL uc_src: got %0h want %0h", desc_src_mac, SRC); end
        n_cmp++; if (accept_cnt !== 16'd1) begin n_bad++; $display("FAIL uc_acc: got %0d want 1", accept_cnt); end
        pop1();
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL uc_popped: got %0h want 0", desc_valid); end
    endtask

    task automatic test_filter();
        send(OTHER, 16'h0800, 11'd61, 1'b0);
        step();
        n_cmp++; if (drop_filter_cnt !== 16'd1) begin n_bad++; $display("FAIL flt_mac: got %0d want 1", drop_filter_cnt); end
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL flt_mac_valid: got %0h want 0", desc_valid); end
        // promisc snapshot at capture applies even though cfg drops back before evaluation
        cfg_promisc = 1'b1;
        send(OTHER, 16'h0800, 11'd62, 1'b0);
        cfg_promisc = 1'b0;
        step();
        n_cmp++; if (accept_cnt !== 16'd2) begin n_bad++; $display("FAIL flt_promisc_acc: got %0d want 2", accept_cnt); end
        n_cmp++; if (desc_len !== 11'd62) begin n_bad++; $display("FAIL flt_promisc_len: got %0d want 62", desc_len); end
        pop1();
        send(BCAST, 16'h0806, 11'd28, 1'b0);
        step();
        n_cmp++; if (desc_valid !== 1'b1 || desc_class !== 2'd0) begin
            n_bad++; $display("FAIL flt_bcast_arp: got valid=%0h class=%0d want valid=1 class=0", desc_valid, desc_class); end
        pop1();
        send(STA, 16'h88CC, 11'd40, 1'b0);
        step();
        n_cmp++; if (drop_filter_cnt !== 16'd2) begin n_bad++; $display("FAIL flt_type: got %0d want 2", drop_filter_cnt); end
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL flt_type_valid: got %0h want 0", desc_valid); end
        send(MCAST, 16'h86DD, 11'd70, 1'b0);
        step();
        n_cmp++; if (drop_filter_cnt !== 16'd3) begin n_bad++; $display("FAIL flt_mcast_off: got %0d want 3", drop_filter_cnt); end
        cfg_accept_mcast = 1'b1;
        send(MCAST, 16'h86DD, 11'd71, 1'b0);
        step();
        n_cmp++; if (desc_valid !== 1'b1 || desc_class !== 2'd2) begin
            n_bad++; $display("FAIL flt_mcast_on: got valid=%0h class=%0d want valid=1 class=2", desc_valid, desc_class); end
        pop1();
        cfg_accept_other = 1'b1;
        send(STA, 16'h88CC, 11'd42, 1'b0);
        step();
        n_cmp++; if (desc_valid !== 1'b1 || desc_class !== 2'd3) begin
            n_bad++; $display("FAIL flt_other_on: got valid=%0h class=%0d want valid=1 class=3", desc_valid, desc_class); end
        pop1();
        cfg_accept_other = 1'b0;
        n_cmp++; if (accept_cnt !== 16'd5) begin n_bad++; $display("FAIL flt_acc_total: got %0d want 5", accept_cnt); end
    endtask

    task automatic test_err_priority();
        send(BCAST, 16'h0806, 11'd28, 1'b1);
        step();
        n_cmp++; if (drop_err_cnt !== 16'd1) begin n_bad++; $display("FAIL err_cnt: got %0d want 1", drop_err_cnt); end
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL err_valid: got %0h want 0", desc_valid); end
        n_cmp++; if (accept_cnt !== 16'd5 || drop_filter_cnt !== 16'd3 || drop_full_cnt !== 16'd0) begin
            n_bad++; $display("FAIL err_others: got acc=%0d flt=%0d full=%0d want 5 3 0",
                              accept_cnt, drop_filter_cnt, drop_full_cnt); end
    endtask

    task automatic test_full();
        desc_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(STA, 16'h0800, LEN_W'(100 + i), 1'b0);
        step();
        n_cmp++; if (accept_cnt !== 16'd9) begin n_bad++; $display("FAIL full_acc: got %0d want 9", accept_cnt); end
        n_cmp++; if (drop_full_cnt !== 16'd2) begin n_bad++; $display("FAIL full_drops: got %0d want 2", drop_full_cnt); end
        n_cmp++; if (desc_len !== 11'd100) begin n_bad++; $display("FAIL full_head: got %0d want 100", desc_len); end
        send(STA, 16'h0800, 11'd110, 1'b0);
        desc_ready = 1'b1;
        step();
        desc_ready = 1'b0;
        n_cmp++; if (drop_full_cnt !== 16'd3) begin n_bad++; $display("FAIL full_pop_same: got %0d want 3", drop_full_cnt); end
        n_cmp++; if (accept_cnt !== 16'd9) begin n_bad++; $display("FAIL full_pop_acc: got %0d want 9", accept_cnt); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (desc_valid !== 1'b1 || desc_len !== LEN_W'(100 + i)) begin
                n_bad++; $display("FAIL full_drain%0d: got valid=%0h len=%0d want 1 %0d", i, desc_valid, desc_len, 100 + i); end
            pop1();
        end
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty: got %0h want 0", desc_valid); end
    endtask

    task automatic test_back_to_back();
        send(STA, 16'h0800, 11'd200, 1'b0);
        send(STA, 16'h0800, 11'd201, 1'b0);
        step();
        send(STA, 16'h0806, 11'd202, 1'b0);
        desc_ready = 1'b1;
        send(STA, 16'h0806, 11'd203, 1'b0);
        desc_ready = 1'b0;
        step();
        n_cmp++; if (accept_cnt !== 16'd13) begin n_bad++; $display("FAIL b2b_acc: got %0d want 13", accept_cnt); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (desc_valid !== 1'b1 || desc_len !== LEN_W'(200 + i)) begin
                n_bad++; $display("FAIL b2b_drain%0d: got valid=%0h len=%0d want 1 %0d", i, desc_valid, desc_len, 200 + i); end
            pop1();
        end
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %0h want 0", desc_valid); end
    endtask

    task automatic test_saturation();
        hdr_dst_mac = STA; hdr_ethertype = 16'h0800; hdr_err = 1'b1; hdr_valid = 1'b1;
        repeat ((1 << CNT_W) + 3) step();
        hdr_valid = 1'b0; hdr_err = 1'b0;
        step(); step();
        n_cmp++; if (drop_err_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_err: got %0h want ffff", drop_err_cnt); end
        n_cmp++; if (accept_cnt !== 16'd13) begin n_bad++; $display("FAIL sat_acc: got %0d want 13", accept_cnt); end
    endtask

    task automatic test_reset_mid();
        send(STA, 16'h0800, 11'd300, 1'b0);
        send(STA, 16'h0800, 11'd301, 1'b0);
        send(STA, 16'h0800, 11'd302, 1'b0);
        n_cmp++; if (desc_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got %0h want 1", desc_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (desc_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %0h want 0", desc_valid); end
        n_cmp++; if ({accept_cnt, drop_err_cnt, drop_filter_cnt, drop_full_cnt} !== '0) begin
            n_bad++; $display("FAIL rmid_cnts: got %0h %0h %0h %0h want all 0",
                              accept_cnt, drop_err_cnt, drop_filter_cnt, drop_full_cnt); end
        step();
        n_cmp++; if (accept_cnt !== 16'd0 || desc_valid !== 1'b0) begin
            n_bad++; $display("FAIL rmid_pending: got acc=%0d valid=%0h want 0 0", accept_cnt, desc_valid); end
    endtask

    initial begin
        reset = 1'b1; cfg_mac = STA; cfg_promisc = 1'b0; cfg_accept_mcast = 1'b0; cfg_accept_other = 1'b0;
        hdr_valid = 1'b0; hdr_dst_mac = '0; hdr_src_mac = '0; hdr_ethertype = '0; hdr_len = '0;
        hdr_err = 1'b0; desc_ready = 1'b0;
        test_reset();
        test_unicast();
        test_filter();
        test_err_priority();
        test_full();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
